// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic pipeline stage registers.
package pipe_skid_stage_pkg;

  // Native datapath word width.
  localparam int BIN_DIG = 32;

  // The encoding doubles as the occupancy count (held entries).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage : pipe_skid_stage_pkg

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter, shared by the performance-monitor counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count enabled cycles; stick at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake, two-entry skid buffer,
// synchronous squash, and a saturating stall-cycle counter.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | nothing held, out_valid=0, in_ready=1
// ONE   | head register holds the oldest entry
// TWO   | head and skid both full, in_ready=0
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int WIDTH = BIN_DIG,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e      state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             pop;

  // Handshake-facing outputs depend on registered state only, so neither
  // in_valid nor out_ready can reach in_ready/out_valid combinationally.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign out_data  = head_q;
  assign occupancy = state_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Occupancy FSM and payload registers; flush wins over every handshake
  // but leaves the payload registers untouched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= ONE;
            head_q  <= in_data;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_q <= TWO;
            skid_q  <= in_data;
          end else if (pop && !accept) begin
            state_q <= EMPTY;
          end else if (accept && pop) begin
            head_q  <= in_data;
          end
        end
        TWO: begin
          if (pop) begin
            state_q <= ONE;
            head_q  <= skid_q;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage (WIDTH=32, CNT_W=2).
module tb_pipe_skid_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_skid_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  // Inputs applied this cycle, outputs expected this cycle (before the edge).
  typedef struct {
    logic             rst;
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             ordy;
    logic             fl;
    logic             e_ov;
    logic             e_ir;
    logic [1:0]       e_occ;
    logic             chk_data;
    logic [WIDTH-1:0] e_data;
    logic [CNT_W-1:0] e_stall;
  } vec_t;

  vec_t vt[$];
  logic [WIDTH-1:0] sb[$];

  task automatic add(input logic rst, input logic iv, input logic [WIDTH-1:0] id,
                     input logic ordy, input logic fl, input logic e_ov,
                     input logic e_ir, input logic [1:0] e_occ, input logic chk_data,
                     input logic [WIDTH-1:0] e_data, input logic [CNT_W-1:0] e_stall);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.chk_data = chk_data;
    v.e_data = e_data; v.e_stall = e_stall;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_word;
    int               drained;

    RST = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    //  rst iv  id        ordy fl | ov ir occ chk data      stall
    add(1, 1, 32'h99,   0, 0,   0, 1, 0, 1, 32'h0,  0);  // reset with in_valid
    add(0, 0, 32'h0,    1, 0,   0, 1, 0, 1, 32'h0,  0);  // still EMPTY
    add(0, 1, 32'h1,    1, 0,   0, 1, 0, 1, 32'h0,  0);  // stream 1
    add(0, 1, 32'h2,    1, 0,   1, 1, 1, 1, 32'h1,  0);
    add(0, 1, 32'h3,    1, 0,   1, 1, 1, 1, 32'h2,  0);
    add(0, 0, 32'h0,    1, 0,   1, 1, 1, 1, 32'h3,  0);
    add(0, 1, 32'hA,    0, 0,   0, 1, 0, 0, 32'h0,  0);  // skid fill
    add(0, 1, 32'hB,    0, 0,   1, 1, 1, 1, 32'hA,  0);
    add(0, 1, 32'hC,    0, 0,   1, 0, 2, 1, 32'hA,  1);  // C refused
    add(0, 0, 32'h0,    1, 0,   1, 0, 2, 1, 32'hA,  2);
    add(0, 0, 32'h0,    1, 0,   1, 1, 1, 1, 32'hB,  2);
    add(0, 0, 32'h0,    0, 0,   0, 1, 0, 0, 32'h0,  2);
    add(1, 0, 32'h0,    0, 0,   0, 1, 0, 0, 32'h0,  2);  // clear stall_cnt
    add(0, 1, 32'h7,    0, 0,   0, 1, 0, 1, 32'h0,  0);
    add(0, 0, 32'h0,    0, 0,   1, 1, 1, 1, 32'h7,  0);  // stall 5 cycles
    add(0, 0, 32'h0,    0, 0,   1, 1, 1, 1, 32'h7,  1);
    add(0, 0, 32'h0,    0, 0,   1, 1, 1, 1, 32'h7,  2);
    add(0, 0, 32'h0,    0, 0,   1, 1, 1, 1, 32'h7,  3);
    add(0, 0, 32'h0,    0, 0,   1, 1, 1, 1, 32'h7,  3);
    add(0, 0, 32'h0,    0, 1,   1, 1, 1, 1, 32'h7,  3);  // flush
    add(0, 0, 32'h0,    0, 0,   0, 1, 0, 0, 32'h0,  3);
    add(0, 1, 32'h11,   0, 0,   0, 1, 0, 0, 32'h0,  3);  // fill to TWO
    add(0, 1, 32'h22,   0, 0,   1, 1, 1, 1, 32'h11, 3);
    add(0, 1, 32'h33,   1, 1,   1, 0, 2, 1, 32'h11, 3);  // flush + pop
    add(0, 1, 32'h55,   1, 0,   0, 1, 0, 0, 32'h0,  3);
    add(0, 0, 32'h0,    1, 0,   1, 1, 1, 1, 32'h55, 3);
    add(0, 1, 32'h66,   0, 0,   0, 1, 0, 0, 32'h0,  3);
    add(0, 1, 32'h77,   0, 1,   1, 1, 1, 1, 32'h66, 3);  // flush + accept
    add(0, 0, 32'h0,    1, 0,   0, 1, 0, 0, 32'h0,  3);
    add(0, 1, 32'h88,   0, 0,   0, 1, 0, 0, 32'h0,  3);
    add(1, 1, 32'h99,   1, 0,   1, 1, 1, 1, 32'h88, 3);  // RST mid-transfer
    add(0, 0, 32'h0,    0, 0,   0, 1, 0, 1, 32'h0,  0);

    tick();
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      RST       = vt[i].rst;
      in_valid  = vt[i].iv;
      in_data   = vt[i].id;
      out_ready = vt[i].ordy;
      flush     = vt[i].fl;
      chk($sformatf("v%0d out_valid", i), WIDTH'(out_valid), WIDTH'(vt[i].e_ov));
      chk($sformatf("v%0d in_ready", i), WIDTH'(in_ready), WIDTH'(vt[i].e_ir));
      chk($sformatf("v%0d occupancy", i), WIDTH'(occupancy), WIDTH'(vt[i].e_occ));
      chk($sformatf("v%0d stall_cnt", i), WIDTH'(stall_cnt), WIDTH'(vt[i].e_stall));
      if (vt[i].chk_data)
        chk($sformatf("v%0d out_data", i), out_data, vt[i].e_data);
      tick();
    end

    // Random accept/pop mix against a FIFO scoreboard.
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb.delete();
    for (int c = 0; c < 120; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      chk("rnd occupancy", WIDTH'(occupancy), WIDTH'(sb.size()));
      chk("rnd out_valid", WIDTH'(out_valid), WIDTH'(sb.size() != 0));
      chk("rnd in_ready", WIDTH'(in_ready), WIDTH'(sb.size() != 2));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL rnd pop: got 0x%0h expected no beat", out_data);
        end else begin
          exp_word = sb.pop_front();
          chk("rnd fifo data", out_data, exp_word);
        end
      end
      if (in_valid && in_ready)
        sb.push_back(in_data);
      tick();
    end

    // Drain what is left, bounded.
    in_valid = 1'b0; out_ready = 1'b1;
    drained = 0;
    while (out_valid && drained < 8) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL drain extra: got 0x%0h expected no beat", out_data);
      end else begin
        exp_word = sb.pop_front();
        chk("drain fifo data", out_data, exp_word);
      end
      drained++;
      tick();
    end
    chk("drain out_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("drain leftover", WIDTH'(sb.size()), WIDTH'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_skid_stage

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised, elastic pipeline stage register for the processor datapath. It sits between two pipeline stages (fetch→decode, decode→exec/dmem, exec→writeback) and replaces the fixed always-advancing stage registers. The block adds a valid/ready handshake with a two-entry skid buffer, a synchronous flush for branch/exception squash, and a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- WIDTH, default BIN_DIG: payload width in bits; WIDTH ≥ 1.
- CNT_W, default 16: width of the stall counter; CNT_W ≥ 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept; depends on registered state only.
- in_data  input  WIDTH  upstream payload.
- flush  input  1  squash all held entries.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  head entry.
- occupancy  output  2  number of held entries (0, 1 or 2).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- States:
  - EMPTY: occupancy 0.
  - ONE: head register full.
  - TWO: head and skid registers full.
- Outputs by state:
  - out_valid = (state != EMPTY).
  - out_data = head register.
  - in_ready = (state != TWO).
- Transitions without flush:
  - EMPTY: accept → ONE, head ← in_data.
  - ONE: accept && !pop → TWO, skid ← in_data.
  - ONE: pop && !accept → EMPTY.
  - ONE: accept && pop → ONE, head ← in_data.
  - ONE: neither → ONE.
  - TWO: pop → ONE, head ← skid.
  - TWO: no pop → TWO. No accept is possible in TWO.
- Flush has priority over all transitions: next state EMPTY.
  - An accept in the flush cycle is consumed and discarded.
  - A pop in the flush cycle is a completed transfer; downstream keeps the data.
  - Payload registers are not cleared by flush. Their contents are don't-care while out_valid=0.
- Order is strictly FIFO. Nothing is dropped or duplicated except on flush.
- stall_cnt:
  - Increments by 1 each cycle with out_valid && !out_ready.
  - Holds at all-ones.
  - Unaffected by flush; cleared only by RST.
- Reset values:
  - State EMPTY; out_valid 0; in_ready 1; occupancy 0.
  - out_data 0; skid register 0; stall_cnt 0.
  - Handshakes in a cycle with RST=1 are ignored.

## Timing
- Latency: accept in cycle N into EMPTY → out_valid=1 with that data in cycle N+1.
- Throughput: one transfer per cycle sustained while out_ready=1.
- Backpressure: out_ready low for one cycle while ONE → accepted beat lands in skid; in_ready drops in the next cycle.
- No combinational path from out_ready or in_valid to in_ready or out_valid. Both outputs are pure functions of registered state.
- Pop from TWO: head takes skid at the edge; in_ready=1 in the following cycle.
- Flush in cycle N: out_valid=0 and in_ready=1 in cycle N+1.
- RST asserted mid-transfer: all state returns to reset values at that edge, regardless of handshakes.

## Structure
- Package defs:
  - BIN_DIG (already present).
  - New typedef pipe_state_e {EMPTY, ONE, TWO}, 2 bits.
  - occupancy equals the state encoding (EMPTY=0, ONE=1, TWO=2).
- Sub-module sat_counter (parameter W; ports CLK, RST, inc, count) implements stall_cnt and is reused for other performance counters.
- Existing stage interfaces instantiate pipe_skid_stage with WIDTH equal to the packed width of their payload bundle.

## Test plan
- Reset then idle:
  - After RST, out_valid=0, in_ready=1, occupancy=0, out_data=0, stall_cnt=0.
  - Drive in_valid=1 with RST=1 → still EMPTY afterwards.
- Streaming, WIDTH=32, out_ready=1:
  - Send 0x1, 0x2, 0x3 on consecutive cycles.
  - out_data shows 0x1, 0x2, 0x3 in cycles N+1..N+3.
  - in_ready stays 1 throughout.
- Skid fill:
  - Send 0xA then 0xB with out_ready=0.
  - occupancy 2, in_ready=0, out_data=0xA.
  - Raise out_ready → 0xA then 0xB delivered; in_ready=1 again after the first pop.
- Stall count, CNT_W=2:
  - Hold one entry with out_ready=0 for 5 cycles → stall_cnt 1, 2, 3, 3, 3.
  - Flush → stall_cnt stays 3.
- Flush in TWO with simultaneous pop:
  - Pop delivers the head; next cycle occupancy=0, out_valid=0.
  - A subsequent send of 0x55 appears one cycle later.
- Simultaneous accept and pop in ONE over 100 random cycles:
  - Scoreboard shows FIFO order.
  - occupancy never exceeds 2; no beat lost or duplicated.
